// File: rtl/efuse_prog_sequencer.sv
// eFuse programming sequencer: walks every bit of a latched word and strobes only the set bits.
// Optional readback check after the walk is enabled by defining EFUSE_VERIFY_EN.
module efuse_prog_sequencer #(
  parameter int NBITS   = 32,
  parameter int ADDR_W  = 5,
  parameter int PULSE_W = 40,
  parameter int GAP_W   = 4,
  parameter int SENSE_W = 4
) (
  input  logic              clk_8M,
  input  logic              rst,
  input  logic              start,
  input  logic [NBITS-1:0]  prog_word,
  input  logic [NBITS-1:0]  efuse_dout,
  output logic [ADDR_W-1:0] efuse_addr,
  output logic              efuse_pgm,
  output logic              efuse_sense,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_count,
  output logic              verify_err
);

  // state | meaning
  // IDLE  | waiting for a start edge
  // SCAN  | test latched bit at r_idx
  // SETUP | address settles, strobe low
  // PULSE | program strobe high for PULSE_W cycles
  // GAP   | recovery, strobe low, address held
  // SENSE | sense strobe high for SENSE_W cycles (verify builds)
  // CHECK | compare readback against latched word (verify builds)
  // DONE  | one-cycle completion pulse
`ifdef EFUSE_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SETUP, S_PULSE, S_GAP, S_SENSE, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SETUP, S_PULSE, S_GAP, S_DONE
  } state_t;
`endif

  localparam int TMAX  = (PULSE_W > GAP_W) ? ((PULSE_W > SENSE_W) ? PULSE_W : SENSE_W)
                                           : ((GAP_W > SENSE_W) ? GAP_W : SENSE_W);
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NBITS - 1);

  state_t            r_state, w_next, w_end_state;
  logic              r_sync1, r_sync2, r_sync3;
  logic [NBITS-1:0]  r_word;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_pgm, r_busy, r_done;
  logic              w_edge, w_bit, w_last, w_tmr_zero;

  assign w_edge     = r_sync2 & ~r_sync3;
  assign w_bit      = r_word[r_idx];
  assign w_last     = (r_idx == LAST);
  assign w_tmr_zero = (r_tmr == '0);

`ifdef EFUSE_VERIFY_EN
  logic             r_sense, r_verr;
  logic [NBITS-1:0] r_dout;
  assign w_end_state = S_SENSE;
  assign efuse_sense = r_sense;
  assign verify_err  = r_verr;
`else
  logic w_unused;
  assign w_unused    = ^efuse_dout;
  assign w_end_state = S_DONE;
  assign efuse_sense = 1'b0;
  assign verify_err  = 1'b0;
`endif

  always_ff @(posedge clk_8M or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_edge) w_next = S_SCAN;
      S_SCAN: begin
        if (w_bit)       w_next = S_SETUP;
        else if (w_last) w_next = w_end_state;
      end
      S_SETUP: w_next = S_PULSE;
      S_PULSE: if (w_tmr_zero) w_next = S_GAP;
      S_GAP:   if (w_tmr_zero) w_next = w_last ? w_end_state : S_SCAN;
`ifdef EFUSE_VERIFY_EN
      S_SENSE: if (w_tmr_zero) w_next = S_CHECK;
      S_CHECK: w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so they are glitch-free
  always_ff @(posedge clk_8M or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_word  <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_pgm   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef EFUSE_VERIFY_EN
      r_sense <= 1'b0;
      r_verr  <= 1'b0;
      r_dout  <= '0;
`endif
    end else begin
      r_sync1 <= start;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      if (r_state == S_IDLE && w_edge) begin
        r_word <= prog_word;
        r_idx  <= '0;
        r_cnt  <= '0;
`ifdef EFUSE_VERIFY_EN
        r_verr <= 1'b0;
`endif
      end

      if (w_next != r_state) begin
        case (w_next)
          S_PULSE: r_tmr <= TMR_W'(PULSE_W - 1);
          S_GAP:   r_tmr <= TMR_W'(GAP_W - 1);
`ifdef EFUSE_VERIFY_EN
          S_SENSE: r_tmr <= TMR_W'(SENSE_W - 1);
`endif
          default: ;
        endcase
      end else if (!w_tmr_zero) begin
        r_tmr <= r_tmr - 1'b1;
      end

      case (r_state)
        S_SCAN: begin
          if (w_bit)        r_addr <= r_idx;
          else if (!w_last) r_idx  <= r_idx + 1'b1;
        end
        S_SETUP: r_cnt <= r_cnt + 1'b1;
        S_GAP:   if (w_tmr_zero && !w_last) r_idx <= r_idx + 1'b1;
`ifdef EFUSE_VERIFY_EN
        S_SENSE: if (w_tmr_zero) r_dout <= efuse_dout;
        S_CHECK: r_verr <= |(r_word & ~r_dout);
`endif
        default: ;
      endcase

      r_pgm  <= (w_next == S_PULSE);
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
`ifdef EFUSE_VERIFY_EN
      r_sense <= (w_next == S_SENSE);
`endif
    end
  end

  assign efuse_addr = r_addr;
  assign efuse_pgm  = r_pgm;
  assign busy       = r_busy;
  assign done       = r_done;
  assign prog_count = r_cnt;

endmodule

// File: tb/tb_efuse_prog_sequencer.sv
// Scoreboard bench for efuse_prog_sequencer: stimulus queues expected passes, a monitor checks them.
// Readback checks apply when built with EFUSE_VERIFY_EN.
module tb_efuse_prog_sequencer;
  localparam int NBITS = 32, ADDR_W = 5, PULSE_W = 40, GAP_W = 4, SENSE_W = 4;
`ifdef EFUSE_VERIFY_EN
  localparam int VEXTRA = SENSE_W + 1;
  localparam bit VEN = 1'b1;
`else
  localparam int VEXTRA = 0;
  localparam bit VEN = 1'b0;
`endif

  logic              clk_8M, rst, start;
  logic [NBITS-1:0]  prog_word, efuse_dout;
  logic [ADDR_W-1:0] efuse_addr;
  logic              efuse_pgm, efuse_sense, busy, done, verify_err;
  logic [ADDR_W:0]   prog_count;

  efuse_prog_sequencer #(.NBITS(NBITS), .ADDR_W(ADDR_W), .PULSE_W(PULSE_W),
                         .GAP_W(GAP_W), .SENSE_W(SENSE_W)) dut (
    .clk_8M(clk_8M), .rst(rst), .start(start), .prog_word(prog_word),
    .efuse_dout(efuse_dout), .efuse_addr(efuse_addr), .efuse_pgm(efuse_pgm),
    .efuse_sense(efuse_sense), .busy(busy), .done(done),
    .prog_count(prog_count), .verify_err(verify_err));

  initial begin
    clk_8M = 1'b0;
    forever #5 clk_8M = ~clk_8M;
  end

  typedef struct {
    int busy_len;
    int cnt;
    bit verr;
  } exp_t;

  exp_t exp_q[$];
  int   exp_addr_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: observes the fuse interface and retires expected passes when busy falls
  logic              prev_busy, prev_pgm, prev_sense;
  logic [ADDR_W-1:0] prev_addr, cur_addr;
  int busy_len, pulse_len, sense_len, nstrobes, ndone, nsense, gap_left;
  exp_t e;

  always @(negedge clk_8M) begin
    if (rst) begin
      prev_busy = 1'b0; prev_pgm = 1'b0; prev_sense = 1'b0;
      prev_addr = efuse_addr; cur_addr = efuse_addr;
      busy_len = 0; pulse_len = 0; sense_len = 0;
      nstrobes = 0; ndone = 0; nsense = 0; gap_left = 0;
    end else begin
      if (efuse_pgm && efuse_sense) check("pgm_sense_exclusive", 1, 0);
      if (busy) busy_len++;
      if (done) begin
        ndone++;
        if (exp_q.size() > 0) begin
          check("done_prog_count", prog_count, exp_q[0].cnt);
          check("done_verify_err", verify_err, exp_q[0].verr);
        end
      end
      if (efuse_pgm && !prev_pgm) begin
        check("setup_addr_settled", prev_addr, efuse_addr);
        if (exp_addr_q.size() == 0) check("unexpected_strobe", 1, 0);
        else check("strobe_addr", efuse_addr, exp_addr_q.pop_front());
        cur_addr = efuse_addr;
        pulse_len = 0;
        nstrobes++;
      end
      if (efuse_pgm) begin
        pulse_len++;
        check("addr_stable_in_pulse", efuse_addr, cur_addr);
      end
      if (!efuse_pgm && prev_pgm) begin
        check("pulse_width", pulse_len, PULSE_W);
        gap_left = GAP_W;
      end
      if (gap_left > 0) begin
        check("gap_low_addr_held", {efuse_pgm, efuse_addr}, {1'b0, cur_addr});
        gap_left--;
      end
      if (efuse_sense) begin
        if (!prev_sense) nsense++;
        sense_len++;
      end
      if (!efuse_sense && prev_sense) begin
        check("sense_width", sense_len, SENSE_W);
        sense_len = 0;
      end
      if (!busy && prev_busy) begin
        if (exp_q.size() == 0) check("unexpected_pass", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("busy_length", busy_len, e.busy_len);
          check("strobe_count", nstrobes, e.cnt);
          check("prog_count_hold", prog_count, e.cnt);
          check("done_pulses", ndone, 1);
          check("sense_pulses", nsense, VEN ? 1 : 0);
          check("verify_err_hold", verify_err, e.verr);
        end
        busy_len = 0; nstrobes = 0; ndone = 0; nsense = 0;
      end
      prev_busy = busy; prev_pgm = efuse_pgm; prev_sense = efuse_sense;
      prev_addr = efuse_addr;
    end
  end

  task automatic run_pass(input logic [NBITS-1:0] word, input logic [NBITS-1:0] dout,
                          input bit extra);
    exp_t x;
    int k;
    bit finished;
    k = 0;
    for (int i = 0; i < NBITS; i++) begin
      if (word[i]) begin
        exp_addr_q.push_back(i);
        k++;
      end
    end
    x.busy_len = NBITS + k * (1 + PULSE_W + GAP_W) + 1 + VEXTRA;
    x.cnt      = k;
    x.verr     = VEN && (|(word & ~dout));
    exp_q.push_back(x);

    @(negedge clk_8M);
    prog_word  = word;
    efuse_dout = dout;
    start      = 1'b1;
    @(posedge clk_8M); @(posedge clk_8M); #1;
    check("latency_edge2_idle", busy, 0);
    @(posedge clk_8M); #1;
    check("latency_edge3_busy", busy, 1);
    prog_word = $urandom();
    if (extra) begin
      repeat (3) begin
        repeat (3) @(negedge clk_8M);
        start = 1'b0;
        repeat (3) @(negedge clk_8M);
        start = 1'b1;
      end
    end
    finished = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk_8M);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) check("pass_timeout", 0, 1);
    start = 1'b0;
    repeat (5) @(negedge clk_8M);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; prog_word = '0; efuse_dout = '0;
    repeat (3) @(negedge clk_8M);
    check("rst_busy", busy, 0);
    check("rst_pgm", efuse_pgm, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_8M);
    check("idle_outputs", {busy, done, efuse_pgm, efuse_sense, verify_err}, 0);
    check("idle_addr", efuse_addr, 0);
    check("idle_prog_count", prog_count, 0);

    run_pass(32'h0000_0000, 32'h0, 1'b0);
    run_pass(32'h0000_0001, 32'h0, 1'b0);
    run_pass(32'h8000_0001, 32'h0, 1'b0);
    run_pass(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_pass(32'h0000_000F, 32'h0000_0007, 1'b0);
    run_pass(32'h0000_000F, 32'h0000_000F, 1'b0);
    repeat (6) run_pass($urandom() & $urandom(), $urandom() | $urandom(), 1'b0);

    // Abort mid-strobe: reset must drop the strobe at once and leave nothing pending
    @(negedge clk_8M);
    prog_word = 32'h1;
    exp_addr_q.push_back(0);
    start = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk_8M); #1;
      if (efuse_pgm) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_strobe_started", seen, 1);
    repeat (10) @(posedge clk_8M);
    #2 rst = 1'b1;
    #1;
    check("abort_pgm_async", efuse_pgm, 0);
    check("abort_busy_async", busy, 0);
    check("abort_prog_count", prog_count, 0);
    start = 1'b0;
    exp_addr_q.delete();
    repeat (3) @(negedge clk_8M);
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk_8M);
      if (busy || efuse_pgm) seen = 1'b1;
    end
    check("no_resume_after_reset", seen, 0);

    run_pass(32'h0000_0005, 32'h0000_0001, 1'b0);
    check("scoreboard_drained", exp_q.size() + exp_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/efuse_prog_sequencer.md
Name: efuse_prog_sequencer

Overview:
Programming controller for the eFuse array. Sequences one full program pass after a start request:
- Latches the program word.
- Walks every bit address in turn.
- Issues a fixed-width program strobe only for bits set to 1.
- Inserts a recovery gap after each strobe.
- Reports busy/done.

It sits between the configuration/start logic and the eFuse macro, replacing ad-hoc pulse generation with a deterministic per-bit schedule.

Parameters:
NBITS, 32, fuse bits per pass; address range 0..NBITS-1
ADDR_W, 5, efuse_addr width; must satisfy 2**ADDR_W >= NBITS
PULSE_W, 40, program strobe width in clk_8M cycles (40 = 5 us); >= 1
GAP_W, 4, low cycles after each strobe with address held; >= 1
SENSE_W, 4, sense strobe width in cycles (used only with EFUSE_VERIFY_EN); >= 1

Ports:
clk_8M  input  1  system clock, 8 MHz
rst  input  1  reset, asynchronous, active-high
start  input  1  start request, asynchronous level; a rising edge requests a pass
prog_word  input  NBITS  bits to blow; sampled at start acceptance
efuse_dout  input  NBITS  fuse sense data (used only with EFUSE_VERIFY_EN)
efuse_addr  output  ADDR_W  bit address being programmed
efuse_pgm  output  1  program strobe to fuse macro
efuse_sense  output  1  sense strobe (used only with EFUSE_VERIFY_EN)
busy  output  1  pass in progress
done  output  1  one-cycle pulse at end of pass
prog_count  output  ADDR_W+1  number of strobes issued in current/last pass
verify_err  output  1  readback mismatch flag (used only with EFUSE_VERIFY_EN)

Behaviour:
- Reset (async, rst=1): all outputs 0. FSM = IDLE. Sync flops = 0. efuse_pgm drops immediately, including mid-pulse. No resume after reset.
- Start detection:
  - start passes through a 2-flop synchronizer plus one delay flop.
  - Edge = sync2 & ~sync3.
  - An edge in IDLE is accepted. Edges in any other state are ignored and not queued.
  - Latency: busy rises on the 3rd clk_8M edge after the start rise.
- On acceptance:
  - prog_word is latched.
  - Bit index = 0, prog_count = 0.
  - verify_err is cleared.
  - FSM -> SCAN.
- FSM states: IDLE, SCAN, SETUP, PULSE, GAP, [SENSE, CHECK], DONE. busy=1 in every state except IDLE.
- SCAN: one cycle, evaluates latched bit[idx].
  - bit=1 -> SETUP.
  - bit=0 and idx<NBITS-1 -> idx+1, stay in SCAN.
  - bit=0 and idx=NBITS-1 -> end of walk.
- SETUP: 1 cycle. efuse_addr=idx, efuse_pgm=0 (address settles before the strobe).
- PULSE: exactly PULSE_W cycles with efuse_pgm=1. efuse_addr is stable. prog_count increments on entry.
- GAP: exactly GAP_W cycles with efuse_pgm=0 and efuse_addr held. Then:
  - idx<NBITS-1 -> idx+1, SCAN.
  - otherwise -> end of walk.
- End of walk -> DONE (or SENSE when verify is enabled).
- DONE: 1 cycle, done=1 -> IDLE.
- efuse_addr:
  - Updates only on SETUP entry; holds its last value otherwise.
  - Is 0 after reset.
- prog_count holds after the pass until the next acceptance.
- Pass duration: busy high for NBITS + k*(1+PULSE_W+GAP_W) + 1 cycles, where k = popcount(prog_word).
- efuse_pgm and efuse_sense are registered, glitch-free, never both 1.
- prog_word changes during a pass have no effect.

Optional Feature:
EFUSE_VERIFY_EN
- Defined:
  - After the walk, SENSE asserts efuse_sense for SENSE_W cycles.
  - efuse_dout is sampled on the last SENSE cycle.
  - CHECK (1 cycle) sets verify_err = |(latched_word & ~sampled_dout).
  - Then DONE.
  - Busy length increases by SENSE_W+1.
  - verify_err holds until the next accepted start or reset.
- Undefined: ports remain. efuse_sense=0, verify_err=0, efuse_dout is ignored, and there are no SENSE/CHECK states.

Test Plan:
- rst=1 mid-PULSE (word 0x1, 10 cycles into strobe) -> efuse_pgm=0 and busy=0 asynchronously. After release, no activity until a new start edge.
- prog_word=0x00000000, start rise -> busy at 3rd edge, high for 33 cycles. efuse_pgm never 1, done pulses once, prog_count=0.
- prog_word=0x00000001 -> one strobe of 40 cycles at efuse_addr=0, preceded by 1 SETUP cycle and followed by 4 GAP cycles. busy high for 78 cycles, prog_count=1.
- prog_word=0x80000001 -> two strobes at addr 0 and 31, each 40 cycles. busy high for 123 cycles, prog_count=2.
- prog_word=0xFFFFFFFF plus extra start edges while busy -> 32 strobes at addr 0..31 in order. busy high for 1473 cycles. Exactly one done pulse; extra edges ignored.
- EFUSE_VERIFY_EN, word 0x0000000F, efuse_dout=0x00000007 -> efuse_sense high for 4 cycles, then verify_err=1 at done. Rerun with dout=0x0000000F -> verify_err=0.
